// File: rtl/dcache_pkg.sv
// Shared types, geometry constants and address-field helpers for the L1 data cache.
package dcache_pkg;

  localparam int TAG_W  = 22;
  localparam int IDX_W  = 5;
  localparam int OFS_W  = 5;
  localparam int WSEL_W = 3;
  localparam int LINES  = 32;
  localparam int LINE_W = 256;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_MISS,
    ST_WRITEBACK,
    ST_REFILL,
    ST_REFILL_DONE
  } state_e;

  // Tag is everything above the index field.
  function automatic logic [TAG_W-1:0] get_tag(input logic [31:0] addr);
    return TAG_W'(addr >> (IDX_W + OFS_W));
  endfunction

  // Line index selects one of the direct-mapped lines.
  function automatic logic [IDX_W-1:0] get_idx(input logic [31:0] addr);
    return IDX_W'(addr >> OFS_W);
  endfunction

  // Word select within a line; the byte offset bits are ignored.
  function automatic logic [WSEL_W-1:0] get_word(input logic [31:0] addr);
    return WSEL_W'(addr >> 2);
  endfunction

endpackage

// File: rtl/dcache_sram.sv
// Cache line storage: valid/dirty bits with async clear, plus unreset tag and data arrays.
module dcache_sram
  import dcache_pkg::*;
#(
  parameter int LINES  = 32,
  parameter int LINE_W = 256
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic [IDX_W-1:0]  rd_idx_i,
  output logic              rd_valid_o,
  output logic              rd_dirty_o,
  output logic [TAG_W-1:0]  rd_tag_o,
  output logic [LINE_W-1:0] rd_line_o,
  input  logic [IDX_W-1:0]  wr_idx_i,
  input  logic              word_we_i,
  input  logic [WSEL_W-1:0] word_sel_i,
  input  logic [31:0]       word_data_i,
  input  logic              fill_we_i,
  input  logic [TAG_W-1:0]  fill_tag_i,
  input  logic [LINE_W-1:0] fill_line_i
);

  logic [LINES-1:0]  valid_q;
  logic [LINES-1:0]  valid_d;
  logic [LINES-1:0]  dirty_q;
  logic [LINES-1:0]  dirty_d;
  logic [TAG_W-1:0]  tag_q  [LINES];
  logic [LINE_W-1:0] data_q [LINES];

  // Combinational read port.
  assign rd_valid_o = valid_q[rd_idx_i];
  assign rd_dirty_o = dirty_q[rd_idx_i];
  assign rd_tag_o   = tag_q[rd_idx_i];
  assign rd_line_o  = data_q[rd_idx_i];

  // A fill installs a clean valid line; a word write marks the line dirty.
  always_comb begin
    valid_d = valid_q;
    dirty_d = dirty_q;
    if (fill_we_i) begin
      valid_d[wr_idx_i] = 1'b1;
      dirty_d[wr_idx_i] = 1'b0;
    end else if (word_we_i) begin
      dirty_d[wr_idx_i] = 1'b1;
    end
  end

  // Status bits are the only state cleared by reset.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else begin
      valid_q <= valid_d;
      dirty_q <= dirty_d;
    end
  end

  // Tag and data arrays: full-line fill or single-word merge.
  always_ff @(posedge clk_i) begin
    if (fill_we_i) begin
      data_q[wr_idx_i] <= fill_line_i;
      tag_q[wr_idx_i]  <= fill_tag_i;
    end else if (word_we_i) begin
      data_q[wr_idx_i][{word_sel_i, 5'b00000} +: 32] <= word_data_i;
    end
  end

endmodule

// File: rtl/dcache_ctrl.sv
// Direct-mapped write-back write-allocate L1 data cache controller with miss FSM.
module dcache_ctrl
  import dcache_pkg::*;
#(
  parameter int LINES  = dcache_pkg::LINES,
  parameter int LINE_W = dcache_pkg::LINE_W
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              p1_req_i,
  input  logic              p1_wr_i,
  input  logic [31:0]       p1_addr_i,
  input  logic [31:0]       p1_data_i,
  output logic [31:0]       p1_data_o,
  output logic              p1_stall_o,
  output logic              mem_req_o,
  output logic              mem_wr_o,
  output logic [31:0]       mem_addr_o,
  output logic [LINE_W-1:0] mem_data_o,
  input  logic [LINE_W-1:0] mem_data_i,
  input  logic              mem_ack_i
);

  state_e state_q;
  state_e state_d;

  logic [TAG_W-1:0]  tag_q;
  logic [TAG_W-1:0]  tag_d;
  logic [IDX_W-1:0]  idx_q;
  logic [IDX_W-1:0]  idx_d;
  logic [WSEL_W-1:0] word_q;
  logic [WSEL_W-1:0] word_d;
  logic              wr_q;
  logic              wr_d;
  logic [31:0]       wdata_q;
  logic [31:0]       wdata_d;

  logic [TAG_W-1:0]  p1_tag;
  logic [IDX_W-1:0]  p1_idx;
  logic [WSEL_W-1:0] p1_word;

  logic [IDX_W-1:0]  rd_idx;
  logic              rd_valid;
  logic              rd_dirty;
  logic [TAG_W-1:0]  rd_tag;
  logic [LINE_W-1:0] rd_line;

  logic [IDX_W-1:0]  wr_idx;
  logic              word_we;
  logic [WSEL_W-1:0] word_sel;
  logic [31:0]       word_data;
  logic              fill_we;

  logic              hit;
  logic              idle_hit;

  assign p1_tag  = get_tag(p1_addr_i);
  assign p1_idx  = get_idx(p1_addr_i);
  assign p1_word = get_word(p1_addr_i);

  // In IDLE the live CPU address is looked up; afterwards only the latched miss index matters.
  assign rd_idx   = (state_q == ST_IDLE) ? p1_idx : idx_q;
  assign hit      = p1_req_i & rd_valid & (rd_tag == p1_tag);
  assign idle_hit = (state_q == ST_IDLE) & hit;

  assign p1_stall_o = p1_req_i & ~idle_hit;

  dcache_sram #(
    .LINES  (LINES),
    .LINE_W (LINE_W)
  ) u_sram (
    .clk_i       (clk_i),
    .rst_ni      (rst_i),
    .rd_idx_i    (rd_idx),
    .rd_valid_o  (rd_valid),
    .rd_dirty_o  (rd_dirty),
    .rd_tag_o    (rd_tag),
    .rd_line_o   (rd_line),
    .wr_idx_i    (wr_idx),
    .word_we_i   (word_we),
    .word_sel_i  (word_sel),
    .word_data_i (word_data),
    .fill_we_i   (fill_we),
    .fill_tag_i  (tag_q),
    .fill_line_i (mem_data_i)
  );

  // State register; reset abandons any transaction in flight.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Copy of the missing access, held for the rest of the miss sequence.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      tag_q   <= '0;
      idx_q   <= '0;
      word_q  <= '0;
      wr_q    <= 1'b0;
      wdata_q <= '0;
    end else begin
      tag_q   <= tag_d;
      idx_q   <= idx_d;
      word_q  <= word_d;
      wr_q    <= wr_d;
      wdata_q <= wdata_d;
    end
  end

  // Next-state logic and capture of the missing access.
  always_comb begin
    state_d = state_q;
    tag_d   = tag_q;
    idx_d   = idx_q;
    word_d  = word_q;
    wr_d    = wr_q;
    wdata_d = wdata_q;
    unique case (state_q)
      ST_IDLE: begin
        if (p1_req_i && !hit) begin
          state_d = ST_MISS;
          tag_d   = p1_tag;
          idx_d   = p1_idx;
          word_d  = p1_word;
          wr_d    = p1_wr_i;
          wdata_d = p1_data_i;
        end
      end
      ST_MISS: begin
        state_d = (rd_valid && rd_dirty) ? ST_WRITEBACK : ST_REFILL;
      end
      ST_WRITEBACK: begin
        if (mem_ack_i) state_d = ST_REFILL;
      end
      ST_REFILL: begin
        if (mem_ack_i) state_d = ST_REFILL_DONE;
      end
      ST_REFILL_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Memory interface, load data and array write controls for each state.
  always_comb begin
    mem_req_o  = 1'b0;
    mem_wr_o   = 1'b0;
    mem_addr_o = '0;
    mem_data_o = '0;
    p1_data_o  = '0;
    fill_we    = 1'b0;
    word_we    = 1'b0;
    wr_idx     = idx_q;
    word_sel   = word_q;
    word_data  = wdata_q;
    unique case (state_q)
      ST_IDLE: begin
        wr_idx    = p1_idx;
        word_sel  = p1_word;
        word_data = p1_data_i;
        if (idle_hit) begin
          p1_data_o = rd_line[{p1_word, 5'b00000} +: 32];
          word_we   = p1_wr_i;
        end
      end
      ST_WRITEBACK: begin
        mem_req_o  = 1'b1;
        mem_wr_o   = 1'b1;
        mem_addr_o = {rd_tag, idx_q, 5'b00000};
        mem_data_o = rd_line;
      end
      ST_REFILL: begin
        mem_req_o  = 1'b1;
        mem_addr_o = {tag_q, idx_q, 5'b00000};
        fill_we    = mem_ack_i;
      end
      ST_REFILL_DONE: begin
        word_we = wr_q;
      end
      default: begin
      end
    endcase
  end

endmodule

// File: tb/tb_dcache_ctrl.sv
// Directed self-checking bench for the data cache controller with a scripted memory responder.
module tb_dcache_ctrl;

  logic         clk;
  logic         rst_n;
  logic         p1_req;
  logic         p1_wr;
  logic [31:0]  p1_addr;
  logic [31:0]  p1_wdata;
  logic [31:0]  p1_rdata;
  logic         p1_stall;
  logic         mem_req;
  logic         mem_wr;
  logic [31:0]  mem_addr;
  logic [255:0] mem_wdata;
  logic [255:0] mem_rdata;
  logic         mem_ack;

  int checks_total  = 0;
  int checks_passed = 0;

  int           stall_cycles;
  logic [31:0]  load_data;
  logic         wb_seen;
  logic         rd_seen;
  logic [31:0]  wb_addr;
  logic [255:0] wb_data;
  logic [31:0]  rd_addr;
  logic         timed_out;

  localparam logic [255:0] LINE_A = 256'h88888888_77777777_66666666_55555555_44444444_33333333_22222222_11111111;
  localparam logic [255:0] LINE_A_DIRTY = 256'h88888888_77777777_66666666_55555555_44444444_DEADBEEF_22222222_11111111;
  localparam logic [255:0] LINE_B = 256'hA0000007_A0000006_A0000005_A0000004_A0000003_A0000002_A0000001_A0000000;
  localparam logic [255:0] LINE_C = 256'hB0000007_B0000006_B0000005_B0000004_B0000003_B0000002_B0000001_B0000000;

  dcache_ctrl dut (
    .clk_i      (clk),
    .rst_i      (rst_n),
    .p1_req_i   (p1_req),
    .p1_wr_i    (p1_wr),
    .p1_addr_i  (p1_addr),
    .p1_data_i  (p1_wdata),
    .p1_data_o  (p1_rdata),
    .p1_stall_o (p1_stall),
    .mem_req_o  (mem_req),
    .mem_wr_o   (mem_wr),
    .mem_addr_o (mem_addr),
    .mem_data_o (mem_wdata),
    .mem_data_i (mem_rdata),
    .mem_ack_i  (mem_ack)
  );

  // Free-running pipeline clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Compare one observed value against its hand-computed expectation.
  task automatic checkOutput(input string tag, input logic [255:0] observed, input logic [255:0] expected);
    checks_total++;
    assert (observed === expected) checks_passed++;
    else $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
  endtask

  // Present one CPU access, answer memory requests after n_ack cycles, and record what happened.
  task automatic applyStimulus(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                               input logic [255:0] line, input int n_ack);
    int  req_cycles;
    bit  done;
    @(negedge clk);
    p1_req       = 1'b1;
    p1_wr        = wr;
    p1_addr      = addr;
    p1_wdata     = wdata;
    mem_rdata    = line;
    mem_ack      = 1'b0;
    stall_cycles = 0;
    load_data    = '0;
    wb_seen      = 1'b0;
    rd_seen      = 1'b0;
    wb_addr      = '0;
    wb_data      = '0;
    rd_addr      = '0;
    req_cycles   = 0;
    done         = 1'b0;
    for (int cyc = 0; cyc < 300 && !done; cyc++) begin
      #1;
      if (!p1_stall) begin
        load_data = p1_rdata;
        done      = 1'b1;
      end else begin
        stall_cycles++;
        if (mem_req) begin
          if (req_cycles == 0) begin
            if (mem_wr) begin
              wb_seen = 1'b1;
              wb_addr = mem_addr;
              wb_data = mem_wdata;
            end else begin
              rd_seen = 1'b1;
              rd_addr = mem_addr;
            end
          end
          req_cycles++;
          if (req_cycles >= n_ack) begin
            mem_ack    = 1'b1;
            req_cycles = 0;
          end
        end
        @(negedge clk);
        mem_ack = 1'b0;
      end
    end
    timed_out = !done;
  endtask

  // Hard stop in case something hangs outside the bounded loops.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog observed=hang expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Directed sequence of cache scenarios.
  initial begin
    rst_n     = 1'b0;
    p1_req    = 1'b1;
    p1_wr     = 1'b0;
    p1_addr   = 32'h0;
    p1_wdata  = 32'h0;
    mem_rdata = '0;
    mem_ack   = 1'b0;

    // Reset state with an access pending: outputs quiet, stall asserted.
    #12;
    checkOutput("rst_mem_req", 256'(mem_req), 256'(1'b0));
    checkOutput("rst_mem_wr", 256'(mem_wr), 256'(1'b0));
    checkOutput("rst_mem_addr", 256'(mem_addr), 256'(32'h0));
    checkOutput("rst_mem_data", mem_wdata, 256'h0);
    checkOutput("rst_p1_data", 256'(p1_rdata), 256'(32'h0));
    checkOutput("rst_stall", 256'(p1_stall), 256'(1'b1));
    @(negedge clk);
    p1_req = 1'b0;
    rst_n  = 1'b1;

    // Cold read miss of address 0 with a 10-cycle read.
    applyStimulus(1'b0, 32'h0000_0000, 32'h0, LINE_A, 10);
    checkOutput("cold_timeout", 256'(timed_out), 256'(1'b0));
    checkOutput("cold_stall", 256'(stall_cycles), 256'(13));
    checkOutput("cold_data", 256'(load_data), 256'(32'h11111111));
    checkOutput("cold_rd_seen", 256'(rd_seen), 256'(1'b1));
    checkOutput("cold_rd_addr", 256'(rd_addr), 256'(32'h0));
    checkOutput("cold_wb_seen", 256'(wb_seen), 256'(1'b0));

    // Read hit on word 1 of the same line.
    applyStimulus(1'b0, 32'h0000_0004, 32'h0, LINE_A, 1);
    checkOutput("hit_stall", 256'(stall_cycles), 256'(0));
    checkOutput("hit_data", 256'(load_data), 256'(32'h22222222));
    checkOutput("hit_no_rd", 256'(rd_seen), 256'(1'b0));
    checkOutput("hit_no_wb", 256'(wb_seen), 256'(1'b0));

    // Store hit to word 2 makes line 0 dirty.
    applyStimulus(1'b1, 32'h0000_0008, 32'hDEADBEEF, LINE_A, 1);
    checkOutput("st_hit_stall", 256'(stall_cycles), 256'(0));

    // Conflicting load at 0x400 forces writeback of the dirty line, then refill.
    applyStimulus(1'b0, 32'h0000_0400, 32'h0, LINE_B, 2);
    checkOutput("evict_timeout", 256'(timed_out), 256'(1'b0));
    checkOutput("evict_wb_seen", 256'(wb_seen), 256'(1'b1));
    checkOutput("evict_wb_addr", 256'(wb_addr), 256'(32'h0));
    checkOutput("evict_wb_data", wb_data, LINE_A_DIRTY);
    checkOutput("evict_rd_addr", 256'(rd_addr), 256'(32'h400));
    checkOutput("evict_stall", 256'(stall_cycles), 256'(7));
    checkOutput("evict_data", 256'(load_data), 256'(32'hA0000000));

    // Hit on the newly installed line.
    applyStimulus(1'b0, 32'h0000_0404, 32'h0, LINE_B, 1);
    checkOutput("new_hit_stall", 256'(stall_cycles), 256'(0));
    checkOutput("new_hit_data", 256'(load_data), 256'(32'hA0000001));

    // Store miss to clean index 1 allocates without writeback.
    applyStimulus(1'b1, 32'h0000_2020, 32'hCAFEF00D, LINE_C, 3);
    checkOutput("alloc_wb_seen", 256'(wb_seen), 256'(1'b0));
    checkOutput("alloc_rd_addr", 256'(rd_addr), 256'(32'h2020));
    checkOutput("alloc_stall", 256'(stall_cycles), 256'(6));
    applyStimulus(1'b0, 32'h0000_2020, 32'h0, LINE_C, 1);
    checkOutput("alloc_ld_stall", 256'(stall_cycles), 256'(0));
    checkOutput("alloc_ld_data", 256'(load_data), 256'(32'hCAFEF00D));

    // Load 0x2420 evicts dirty line 1; reset while the writeback is outstanding.
    @(negedge clk);
    p1_req  = 1'b1;
    p1_wr   = 1'b0;
    p1_addr = 32'h0000_2420;
    @(negedge clk);
    @(negedge clk);
    #1;
    checkOutput("wb_req", 256'(mem_req), 256'(1'b1));
    checkOutput("wb_wr", 256'(mem_wr), 256'(1'b1));
    checkOutput("wb_addr", 256'(mem_addr), 256'(32'h2020));
    rst_n  = 1'b0;
    p1_req = 1'b0;
    #1;
    checkOutput("mid_rst_req", 256'(mem_req), 256'(1'b0));
    @(negedge clk);
    rst_n = 1'b1;

    // Previously cached 0x2020 now misses cleanly; ack in the first read cycle.
    applyStimulus(1'b0, 32'h0000_2020, 32'h0, LINE_C, 1);
    checkOutput("zl_timeout", 256'(timed_out), 256'(1'b0));
    checkOutput("zl_wb_seen", 256'(wb_seen), 256'(1'b0));
    checkOutput("zl_rd_addr", 256'(rd_addr), 256'(32'h2020));
    checkOutput("zl_stall", 256'(stall_cycles), 256'(4));
    checkOutput("zl_data", 256'(load_data), 256'(32'hB0000000));

    @(negedge clk);
    p1_req = 1'b0;
    @(negedge clk);
    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule
